// File: rtl/mouse_arbiter_if.sv
// Packet-bus bundle between the two mouse packet sources and the merged Kempston-side bus.
interface mouse_arbiter_if;
  logic [24:0] in0;
  logic [24:0] in1;
  logic [1:0]  en;
  logic [24:0] out;
  logic        last;
  logic [1:0]  ovf;

  modport master (output in0, in1, en, input out, last, ovf);
  modport slave  (input in0, in1, en, output out, last, ovf);
endinterface

// File: rtl/mouse_arbiter.sv
// Two-source round-robin merger for toggle-strobed PS/2 mouse packets with enforced output spacing.
// Define MOUSE_ARB_MERGE_EN to coalesce events into a full buffer instead of dropping them.
module mouse_arbiter #(
  parameter int GAP = 4
) (
  input  logic           clk_sys,
  input  logic           reset,
  mouse_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

  // ISSUE is the first cycle after the toggle, so the counter covers the remaining GAP-1.
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [24:0] out_q, out_d;
  logic        last_q, last_d;
  logic [1:0]  ovf_q, ovf_d;
  logic [1:0]  tog_q, tog_d;
  logic [1:0]  pend_q, pend_d;
  logic [2:0]  btn_q [2];
  logic [2:0]  btn_d [2];
  logic [8:0]  dx_q [2];
  logic [8:0]  dx_d [2];
  logic [8:0]  dy_q [2];
  logic [8:0]  dy_d [2];

  logic [24:0] pkt [2];
  logic [1:0]  ev;
  logic [1:0]  iss;
  logic [1:0]  elig;
  logic        issue_go;
  logic        sel;
  logic        unused_pkt_bits;

  assign pkt[0] = bus.in0;
  assign pkt[1] = bus.in1;
  assign unused_pkt_bits = ^{pkt[0][7:6], pkt[0][3], pkt[1][7:6], pkt[1][3]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign ev[gi]  = pkt[gi][24] ^ tog_q[gi];
      assign iss[gi] = issue_go && (sel == 1'(gi));
    end
  endgenerate

`ifdef MOUSE_ARB_MERGE_EN
  function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {a[8], a} + {b[8], b};
    if (s[9] != s[8]) return s[9] ? 9'h100 : 9'h0FF;
    return s[8:0];
  endfunction
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    elig     = pend_q & bus.en;
    sel      = (elig == 2'b11) ? ~last_q : elig[1];
    issue_go = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          issue_go = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_GAP: state_d = (cnt_q == 8'd0) ? ST_IDLE : ST_GAP;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (issue_go) begin
      out_d  = {~out_q[24], dy_q[sel][7:0], dx_q[sel][7:0], 2'b00,
                dy_q[sel][8], dx_q[sel][8], 1'b1, btn_q[sel]};
      last_d = sel;
      cnt_d  = GAP_LOAD;
    end else if (state_q != ST_IDLE && cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Capture path: the issuing slot is free this cycle, so a same-cycle event reloads it.
  always_comb begin
    tog_d  = {pkt[1][24], pkt[0][24]};
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int n = 0; n < 2; n++) begin
      btn_d[n] = btn_q[n];
      dx_d[n]  = dx_q[n];
      dy_d[n]  = dy_q[n];
      if (iss[n]) pend_d[n] = 1'b0;
      if (!bus.en[n]) begin
        pend_d[n] = 1'b0;
      end else if (ev[n]) begin
        if (!pend_q[n] || iss[n]) begin
          btn_d[n]  = pkt[n][2:0];
          dx_d[n]   = {pkt[n][4], pkt[n][15:8]};
          dy_d[n]   = {pkt[n][5], pkt[n][23:16]};
          pend_d[n] = 1'b1;
        end else begin
`ifdef MOUSE_ARB_MERGE_EN
          btn_d[n] = pkt[n][2:0];
          dx_d[n]  = sat_add(dx_q[n], {pkt[n][4], pkt[n][15:8]});
          dy_d[n]  = sat_add(dy_q[n], {pkt[n][5], pkt[n][23:16]});
`else
          ovf_d[n] = 1'b1;
`endif
        end
      end
    end
`ifdef MOUSE_ARB_MERGE_EN
    ovf_d = 2'b00;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q  <= 8'd0;
      out_q  <= 25'h0000008;
      last_q <= 1'b1;
      ovf_q  <= 2'b00;
      pend_q <= 2'b00;
      tog_q  <= {pkt[1][24], pkt[0][24]};
      for (int n = 0; n < 2; n++) begin
        btn_q[n] <= 3'd0;
        dx_q[n]  <= 9'd0;
        dy_q[n]  <= 9'd0;
      end
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
      pend_q <= pend_d;
      tog_q  <= tog_d;
      for (int n = 0; n < 2; n++) begin
        btn_q[n] <= btn_d[n];
        dx_q[n]  <= dx_d[n];
        dy_q[n]  <= dy_d[n];
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.last = last_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_mouse_arbiter.sv
// Directed bench for mouse_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_mouse_arbiter;
  localparam int GAP = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  mouse_arbiter_if bus();

  mouse_arbiter #(.GAP(GAP)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic        rst;
    logic [24:0] in0;
    logic [24:0] in1;
    logic [1:0]  en;
    logic [24:0] exp_out;
    logic        exp_last;
    logic [1:0]  exp_ovf;
  } vec_t;

  vec_t        vecs[$];
  int          n_run  = 0;
  int          n_fail = 0;
  int          iss_cyc[$];
  logic        iss_src[$];
  logic        ptog;
  int          cnt;
  int          ntog;
  logic [24:0] pa, pb, pc, oa, ob, oc, z, exp_m;
  logic [1:0]  exp_ovf_m;

  function automatic logic [24:0] pin(input logic tog, input logic [2:0] b,
                                      input logic [8:0] dx, input logic [8:0] dy);
    return {tog, dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 1'b0, b};
  endfunction

  function automatic logic [24:0] pout(input logic tog, input logic [2:0] b,
                                       input logic [8:0] dx, input logic [8:0] dy);
    return {tog, dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 1'b1, b};
  endfunction

  function automatic void addv(input logic r, input logic [24:0] a, input logic [24:0] b,
                               input logic [1:0] e, input logic [24:0] o, input logic l,
                               input logic [1:0] v);
    vec_t t;
    t.rst = r; t.in0 = a; t.in1 = b; t.en = e;
    t.exp_out = o; t.exp_last = l; t.exp_ovf = v;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic count_toggles(input int cycles, output int n);
    logic p;
    n = 0;
    p = bus.out[24];
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (bus.out[24] !== p) begin
        n++;
        p = bus.out[24];
      end
    end
  endtask

  initial begin
    bus.in0 = '0;
    bus.in1 = '0;
    bus.en  = 2'b11;
    z  = 25'h0;
    pa = pin(1'b1, 3'b001, 9'd5, 9'h1FD);
    oa = pout(1'b1, 3'b001, 9'd5, 9'h1FD);
    pb = pin(1'b0, 3'b010, 9'h1FF, 9'd2);
    ob = pout(1'b1, 3'b010, 9'h1FF, 9'd2);
    pc = pin(1'b1, 3'b100, 9'd16, 9'h180);
    oc = pout(1'b0, 3'b100, 9'd16, 9'h180);

    // reset, then single event on source 0
    addv(1'b1, z,  z, 2'b11, 25'h0000008, 1'b1, 2'b00);
    addv(1'b0, pa, z, 2'b11, 25'h0000008, 1'b1, 2'b00);
    addv(1'b0, pa, z, 2'b11, oa,          1'b0, 2'b00);
    for (int i = 0; i < 4; i++) addv(1'b0, pa, z, 2'b11, oa, 1'b0, 2'b00);
    // reset, then simultaneous events on both sources
    addv(1'b1, pa, z,  2'b11, 25'h0000008, 1'b1, 2'b00);
    addv(1'b0, pb, pc, 2'b11, 25'h0000008, 1'b1, 2'b00);
    addv(1'b0, pb, pc, 2'b11, ob,          1'b0, 2'b00);
    for (int i = 0; i < 4; i++) addv(1'b0, pb, pc, 2'b11, ob, 1'b0, 2'b00);
    addv(1'b0, pb, pc, 2'b11, oc, 1'b1, 2'b00);
    addv(1'b0, pb, pc, 2'b11, oc, 1'b1, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      bus.in0 = vecs[i].in0;
      bus.in1 = vecs[i].in1;
      bus.en  = vecs[i].en;
      tick();
      chk($sformatf("vec%0d.out", i),  bus.out,  vecs[i].exp_out);
      chk($sformatf("vec%0d.last", i), bus.last, vecs[i].exp_last);
      chk($sformatf("vec%0d.ovf", i),  bus.ovf,  vecs[i].exp_ovf);
    end

    // fairness: both sources toggle every cycle
    reset = 1'b1; tick(); reset = 1'b0;
    ptog = bus.out[24];
    for (int c = 0; c < 45; c++) begin
      bus.in0[24] = ~bus.in0[24];
      bus.in1[24] = ~bus.in1[24];
      tick();
      if (bus.out[24] !== ptog) begin
        ptog = bus.out[24];
        iss_cyc.push_back(c);
        iss_src.push_back(bus.last);
      end
    end
    chk("fair.count_ge6", 32'(iss_cyc.size() >= 6), 32'd1);
    if (iss_cyc.size() >= 6) begin
      chk("fair.first_cycle", iss_cyc[0], 1);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("fair.src%0d", i), iss_src[i], 32'(i % 2));
        if (i > 0) chk($sformatf("fair.space%0d", i), iss_cyc[i] - iss_cyc[i-1], GAP + 1);
      end
    end

    // full-buffer behaviour: two source-1 events inside one gap window
    reset = 1'b1; bus.in0 = z; bus.in1 = z; tick(); reset = 1'b0;
    bus.in0 = pin(1'b1, 3'b001, 9'd1, 9'd1); tick(); tick();
    chk("full.src0_issue", bus.out, pout(1'b1, 3'b001, 9'd1, 9'd1));
    bus.in1 = pin(1'b1, 3'b001, 9'd200, 9'd0); tick();
    bus.in1 = pin(1'b0, 3'b010, 9'd100, 9'd0); tick();
    cnt  = 0;
    ptog = bus.out[24];
    while (bus.out[24] === ptog && cnt < 12) begin
      tick();
      cnt++;
    end
`ifdef MOUSE_ARB_MERGE_EN
    exp_m     = pout(1'b0, 3'b010, 9'h0FF, 9'd0);
    exp_ovf_m = 2'b00;
`else
    exp_m     = pout(1'b0, 3'b001, 9'd200, 9'd0);
    exp_ovf_m = 2'b10;
`endif
    chk("full.wait", cnt, 3);
    chk("full.out", bus.out, exp_m);
    chk("full.last", bus.last, 1'b1);
    chk("full.ovf", bus.ovf, exp_ovf_m);
    count_toggles(10, ntog);
    chk("full.single_issue", ntog, 0);

    // enable handling
    reset = 1'b1; tick(); reset = 1'b0;
    bus.en = 2'b01;
    bus.in1[24] = ~bus.in1[24];
    count_toggles(8, ntog);
    chk("dis.src1_ignored", ntog, 0);
    bus.en  = 2'b11;
    bus.in0 = pin(~bus.in0[24], 3'b011, 9'd7, 9'd9); tick();
    bus.en  = 2'b10; tick();
    bus.en  = 2'b11;
    count_toggles(8, ntog);
    chk("dis.pend_flushed", ntog, 0);
    chk("dis.out_idle", bus.out, 25'h0000008);
    bus.in0 = pin(~bus.in0[24], 3'b100, 9'h1F0, 9'd20); tick();
    chk("dis.after_t1", bus.out, 25'h0000008);
    tick();
    chk("dis.after_t2", bus.out, pout(1'b1, 3'b100, 9'h1F0, 9'd20));
    chk("dis.last", bus.last, 1'b0);

    // reset during the gap window
    reset = 1'b1; tick(); reset = 1'b0;
    bus.in0 = pin(~bus.in0[24], 3'b001, 9'd3, 9'd4);
    bus.in1 = pin(~bus.in1[24], 3'b010, 9'd5, 9'd6);
    tick(); tick();
    chk("rst.pre_issue", bus.out, pout(1'b1, 3'b001, 9'd3, 9'd4));
    tick();
    reset = 1'b1; tick();
    chk("rst.out", bus.out, 25'h0000008);
    chk("rst.last", bus.last, 1'b1);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rst.no_stale", bus.out, 25'h0000008);
    bus.in0 = pin(~bus.in0[24], 3'b110, 9'd50, 9'h1CE); tick();
    chk("rst.t1", bus.out, 25'h0000008);
    tick();
    chk("rst.t2", bus.out, pout(1'b1, 3'b110, 9'd50, 9'h1CE));
    chk("rst.t2_last", bus.last, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
